// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, totals helper and sync polarity encoding for the
// parametrised VGA timing generator.
package vga_timing_pkg;

  // Default 640x480@60 timing (25.175 MHz nominal pixel rate)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic {
    POL_ACTIVE_LOW  = 1'b0,
    POL_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Drive level of a sync line given its asserted polarity.
  function automatic logic sync_level(input logic pol, input logic asserted);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bus produced by vga_timing_gen and consumed by the pixel pipeline.
interface vga_timing_gen_if #(
  parameter int CNT_W     = 11,
  parameter int TILE_LOG2 = 5
);
  logic                       hsync_o;
  logic                       vsync_o;
  logic                       active_o;
  logic                       active_dly_o;
  logic [CNT_W-1:0]           x_o;
  logic [CNT_W-1:0]           y_o;
  logic [CNT_W-TILE_LOG2-1:0] tile_x_o;
  logic [CNT_W-TILE_LOG2-1:0] tile_y_o;
  logic [TILE_LOG2-1:0]       sub_y_o;
  logic                       line_start_o;
  logic                       frame_start_o;

  modport master (
    output hsync_o, vsync_o, active_o, active_dly_o, x_o, y_o,
           tile_x_o, tile_y_o, sub_y_o, line_start_o, frame_start_o
  );

  modport slave (
    input  hsync_o, vsync_o, active_o, active_dly_o, x_o, y_o,
           tile_x_o, tile_y_o, sub_y_o, line_start_o, frame_start_o
  );
endinterface

// File: rtl/vga_timing_gen_enable_delay_line.sv
// Shift register of DEPTH entries that advances only on enabled cycles;
// DEPTH = 0 degenerates to a wire.
module enable_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_i, en_i, rst_val};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) stages[i] <= rst_val;
      end else if (en_i) begin
        stages[0] <= d;
        for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
    end

    assign q = stages[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator: pixel-enable driven h/v counters, a stage-1
// register of coordinates/decodes, and a delay line aligning syncs to the pixel mux.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HS_POL    = bit'(POL_ACTIVE_LOW),
  parameter bit VS_POL    = bit'(POL_ACTIVE_LOW),
  parameter int TILE_LOG2 = 5,
  parameter int MUX_DELAY = 2,
  parameter int CNT_W     = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int EW      = CNT_W + 1;

  if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end
  if (TILE_LOG2 < 1 || TILE_LOG2 >= CNT_W) begin : g_bad_tile
    $error("vga_timing_gen: TILE_LOG2 must be in 1..CNT_W-1");
  end
  if (MUX_DELAY < 0 || MUX_DELAY > 15) begin : g_bad_delay
    $error("vga_timing_gen: MUX_DELAY must be in 0..15");
  end

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  // One extra bit so porch/sync edges equal to 2**CNT_W still compare correctly
  localparam logic [EW-1:0]    H_ACT_E = EW'(H_ACTIVE);
  localparam logic [EW-1:0]    HS_BEG  = EW'(H_ACTIVE + H_FP);
  localparam logic [EW-1:0]    HS_END  = EW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [EW-1:0]    V_ACT_E = EW'(V_ACTIVE);
  localparam logic [EW-1:0]    VS_BEG  = EW'(V_ACTIVE + V_FP);
  localparam logic [EW-1:0]    VS_END  = EW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h, v;
  logic [CNT_W-1:0] x_q, y_q;
  logic             active_q, hs_raw, vs_raw;
  logic             line_start_q, frame_start_q;
  logic [2:0]       dly_q;

  logic [EW-1:0] h_e, v_e;
  logic          h_last, v_last, hs_on, vs_on, act_on;

  assign h_e    = {1'b0, h};
  assign v_e    = {1'b0, v};
  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);
  assign hs_on  = (h_e >= HS_BEG) && (h_e < HS_END);
  assign vs_on  = (v_e >= VS_BEG) && (v_e < VS_END);
  assign act_on = (h_e < H_ACT_E) && (v_e < V_ACT_E);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h <= '0;
      v <= '0;
    end else if (en_i) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      hs_raw   <= ~HS_POL;
      vs_raw   <= ~VS_POL;
    end else if (en_i) begin
      x_q      <= h;
      y_q      <= v;
      active_q <= act_on;
      hs_raw   <= sync_level(HS_POL, hs_on);
      vs_raw   <= sync_level(VS_POL, vs_on);
    end
  end

  // Strobes reload every clk so they stay one clk wide when en_i stays low
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= en_i && (h == '0);
      frame_start_q <= en_i && (h == '0) && (v == '0);
    end
  end

  enable_delay_line #(
    .WIDTH(3),
    .DEPTH(MUX_DELAY)
  ) u_sync_dly (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .rst_val({~HS_POL, ~VS_POL, 1'b0}),
    .d      ({hs_raw, vs_raw, active_q}),
    .q      (dly_q)
  );

  assign vga.hsync_o       = dly_q[2];
  assign vga.vsync_o       = dly_q[1];
  assign vga.active_dly_o  = dly_q[0];
  assign vga.active_o      = active_q;
  assign vga.x_o           = x_q;
  assign vga.y_o           = y_q;
  assign vga.tile_x_o      = x_q[CNT_W-1:TILE_LOG2];
  assign vga.tile_y_o      = y_q[CNT_W-1:TILE_LOG2];
  assign vga.sub_y_o       = y_q[TILE_LOG2-1:0];
  assign vga.line_start_o  = line_start_q;
  assign vga.frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-timing instances (MUX_DELAY 0 and 2) checked
// every clk against a position-count model, plus literal timing measurements.
module tb_vga_timing_gen;

  localparam int HT    = 14;
  localparam int VT    = 8;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(11), .TILE_LOG2(2)) bus_a ();
  vga_timing_gen_if #(.CNT_W(11), .TILE_LOG2(2)) bus_b ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .TILE_LOG2(2), .MUX_DELAY(0), .CNT_W(11)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .vga(bus_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .TILE_LOG2(2), .MUX_DELAY(2), .CNT_W(11)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .vga(bus_b)
  );

  typedef struct {
    int x;
    int y;
    bit act;
    bit hs;
    bit vs;
  } pix_t;

  // Outputs implied by screen position p (p < 0 means nothing has propagated yet)
  function automatic pix_t pixel_at(input int p);
    pix_t r;
    if (p < 0) begin
      r.x = 0; r.y = 0; r.act = 1'b0; r.hs = 1'b1; r.vs = 1'b1;
    end else begin
      r.x   = p % HT;
      r.y   = (p / HT) % VT;
      r.act = (r.x < 8) && (r.y < 4);
      r.hs  = !((r.x >= 10) && (r.x < 13));
      r.vs  = !((r.y >= 5) && (r.y < 7));
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkBus(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] tx, input logic [31:0] ty,
                          input logic [31:0] sy, input logic act, input logic hs,
                          input logic vs, input logic actd, input logic ls,
                          input logic fs, input pix_t s1, input pix_t dl,
                          input bit els, input bit efs);
    checkOutput({tag, ".x_o"},          x,        s1.x);
    checkOutput({tag, ".y_o"},          y,        s1.y);
    checkOutput({tag, ".tile_x_o"},     tx,       s1.x / 4);
    checkOutput({tag, ".tile_y_o"},     ty,       s1.y / 4);
    checkOutput({tag, ".sub_y_o"},      sy,       s1.y % 4);
    checkOutput({tag, ".active_o"},     32'(act),  32'(s1.act));
    checkOutput({tag, ".hsync_o"},      32'(hs),   32'(dl.hs));
    checkOutput({tag, ".vsync_o"},      32'(vs),   32'(dl.vs));
    checkOutput({tag, ".active_dly_o"}, 32'(actd), 32'(dl.act));
    checkOutput({tag, ".line_start_o"}, 32'(ls),   32'(els));
    checkOutput({tag, ".frame_start_o"},32'(fs),   32'(efs));
  endtask

  // Model: n = enabled clk edges since reset = current counter position
  initial begin
    int   n;
    bit   en_s, rst_s, exp_ls, exp_fs;
    pix_t s1, da, db;
    n = 0;
    forever begin
      @(posedge clk);
      en_s = en;
      rst_s = rst;
      if (rst_s) begin
        n = 0;
        exp_ls = 1'b0;
        exp_fs = 1'b0;
      end else begin
        exp_ls = en_s && (n % HT == 0);
        exp_fs = en_s && (n % FRAME == 0);
        if (en_s) n++;
      end
      s1 = rst_s ? pixel_at(-1) : pixel_at(n - 1);
      da = s1;
      db = rst_s ? pixel_at(-1) : pixel_at(n - 3);
      #1;
      checkBus("a", 32'(bus_a.x_o), 32'(bus_a.y_o), 32'(bus_a.tile_x_o),
               32'(bus_a.tile_y_o), 32'(bus_a.sub_y_o), bus_a.active_o,
               bus_a.hsync_o, bus_a.vsync_o, bus_a.active_dly_o,
               bus_a.line_start_o, bus_a.frame_start_o, s1, da, exp_ls, exp_fs);
      checkBus("b", 32'(bus_b.x_o), 32'(bus_b.y_o), 32'(bus_b.tile_x_o),
               32'(bus_b.tile_y_o), 32'(bus_b.sub_y_o), bus_b.active_o,
               bus_b.hsync_o, bus_b.vsync_o, bus_b.active_dly_o,
               bus_b.line_start_o, bus_b.frame_start_o, s1, db, exp_ls, exp_fs);
    end
  end

  // en_period > 0: en every en_period clks plus literal timing checks; 0: random en
  task automatic applyStimulus(input int cycles, input int en_period);
    int last_fs = -1, fs_period = -1, last_ls = -1, ls_period = -1;
    int h_run = 0, h_len = -1, v_run = 0, v_len = -1;
    int act_cnt = 0, act_frame = -1, bad_hx = 0, bad_vy = 0, wide = 0;
    int en_idx = 0, x10_idx = -1, hfall_idx = -1;
    bit h_armed = 0, v_armed = 0, fs_seen = 0, prev_fs = 0, prev_ls = 0;
    bit prev_fsb = 0, prev_hb = 1, seen_x7 = 0, seen_y6 = 0;
    logic [10:0] prev_xb = '0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus_a.frame_start_o) begin
        if (last_fs >= 0) fs_period = c - last_fs;
        if (fs_seen) act_frame = act_cnt;
        fs_seen = 1;
        act_cnt = 0;
        last_fs = c;
      end
      if (bus_a.active_o) act_cnt++;
      if (bus_a.line_start_o) begin
        if (last_ls >= 0) ls_period = c - last_ls;
        last_ls = c;
      end
      if (!bus_a.hsync_o) begin
        if (h_armed) h_run++;
        if (bus_a.x_o < 10 || bus_a.x_o > 12) bad_hx++;
      end else begin
        if (h_armed && h_run > 0) h_len = h_run;
        h_run = 0;
        h_armed = 1;
      end
      if (!bus_a.vsync_o) begin
        if (v_armed) v_run++;
        if (bus_a.y_o < 5 || bus_a.y_o > 6) bad_vy++;
      end else begin
        if (v_armed && v_run > 0) v_len = v_run;
        v_run = 0;
        v_armed = 1;
      end
      if ((bus_a.frame_start_o && prev_fs) || (bus_a.line_start_o && prev_ls) ||
          (bus_b.frame_start_o && prev_fsb)) wide++;
      prev_fs  = bus_a.frame_start_o;
      prev_ls  = bus_a.line_start_o;
      prev_fsb = bus_b.frame_start_o;
      if (c > 0 && bus_b.x_o == 11'd10 && prev_xb != 11'd10 && x10_idx < 0)
        x10_idx = en_idx;
      if (prev_hb && !bus_b.hsync_o && x10_idx >= 0 && hfall_idx < 0)
        hfall_idx = en_idx;
      prev_hb = bus_b.hsync_o;
      prev_xb = bus_b.x_o;
      if (en_period > 0 && bus_a.x_o == 11'd7 && !seen_x7) begin
        seen_x7 = 1;
        checkOutput("tile_x_at_x7", 32'(bus_a.tile_x_o), 1);
      end
      if (en_period > 0 && bus_a.y_o == 11'd6 && !seen_y6) begin
        seen_y6 = 1;
        checkOutput("tile_y_at_y6", 32'(bus_a.tile_y_o), 1);
        checkOutput("sub_y_at_y6", 32'(bus_a.sub_y_o), 2);
      end
      en = (en_period == 0) ? 1'($urandom_range(0, 1)) : (c % en_period == 0);
      if (en) en_idx++;
    end
    if (en_period > 0) begin
      checkOutput("frame_period_clks", fs_period, 112 * en_period);
      checkOutput("line_period_clks", ls_period, 14 * en_period);
      checkOutput("hsync_low_clks", h_len, 3 * en_period);
      checkOutput("vsync_low_clks", v_len, 28 * en_period);
      checkOutput("hsync_low_bad_x", bad_hx, 0);
      checkOutput("vsync_low_bad_y", bad_vy, 0);
      checkOutput("active_clks_per_frame", act_frame, 32 * en_period);
      checkOutput("saw_x7", 32'(seen_x7), 1);
      checkOutput("saw_y6", 32'(seen_y6), 1);
      checkOutput("b_hsync_fall_after_x10", hfall_idx - x10_idx, 2);
    end
    checkOutput("strobe_wider_than_1clk", wide, 0);
  endtask

  initial begin
    bit hit;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hsync", 32'(bus_a.hsync_o), 1);
    checkOutput("reset_vsync", 32'(bus_b.vsync_o), 1);
    checkOutput("reset_x", 32'(bus_a.x_o), 0);
    rst = 1'b0;

    $display("[TB] phase: en every clk");
    applyStimulus(260, 1);
    $display("[TB] phase: en every 4th clk");
    applyStimulus(1400, 4);
    $display("[TB] phase: random en");
    applyStimulus(400, 0);

    $display("[TB] phase: reset mid-frame");
    hit = 0;
    en = 1'b1;
    for (int g = 0; g < 300 && !hit; g++) begin
      @(negedge clk);
      if (bus_a.x_o == 11'd5 && bus_a.y_o == 11'd3) hit = 1;
    end
    checkOutput("reach_x5_y3", 32'(hit), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_a_hsync", 32'(bus_a.hsync_o), 1);
    checkOutput("midreset_a_vsync", 32'(bus_a.vsync_o), 1);
    checkOutput("midreset_b_hsync", 32'(bus_b.hsync_o), 1);
    checkOutput("midreset_b_vsync", 32'(bus_b.vsync_o), 1);
    checkOutput("midreset_a_x", 32'(bus_a.x_o), 0);
    checkOutput("midreset_a_active", 32'(bus_a.active_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_frame_start", 32'(bus_a.frame_start_o), 1);
    checkOutput("post_reset_line_start", 32'(bus_b.line_start_o), 1);
    checkOutput("post_reset_x", 32'(bus_a.x_o), 0);

    applyStimulus(300, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
